// File: rtl/kara_pkg.sv
// Shared widths, FSM encodings and constants for the kara restoring divider.
package kara_pkg;
    localparam int DW = 8;
    localparam int ZW = 16;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_CHECK = 2'b01;
    localparam logic [1:0] S_ITER  = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    localparam logic [2:0] ITER_LAST = 3'd7;
    localparam logic [DW-1:0] SAT = 8'hFF;
endpackage

// File: rtl/kara_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] i_p,
    input  logic          i_inbit,
    input  logic [DW-1:0] i_xr,
    output logic [DW:0]   o_p_next,
    output logic          o_qbit
);
    logic [DW:0] w_t;
    logic [DW:0] w_x;

    assign w_t = {i_p, i_inbit};
    assign w_x = {1'b0, i_xr};

    always_comb begin
        o_p_next = w_t;
        o_qbit   = 1'b0;
        if (w_t >= w_x) begin
            o_p_next = w_t - w_x;
            o_qbit   = 1'b1;
        end
    end
endmodule

// File: rtl/kara_divider.sv
// Sequential restoring divider: 2*DW-bit dividend by DW-bit divisor, one quotient bit per clock.
// Handshake: start is sampled only in IDLE; done pulses for one cycle when Q/R/flags are valid.
module kara_divider #(
    parameter int DW = kara_pkg::DW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2*DW-1:0] Z,
    input  logic [DW-1:0]   X,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   Q,
    output logic [DW-1:0]   R,
    output logic            div_zero,
    output logic            overflow
);
    import kara_pkg::S_IDLE;
    import kara_pkg::S_CHECK;
    import kara_pkg::S_ITER;
    import kara_pkg::S_DONE;
    import kara_pkg::ITER_LAST;
    import kara_pkg::SAT;

    logic [1:0]    r_state;
    logic [DW-1:0] r_xr;
    logic [DW:0]   r_p;
    logic [DW-1:0] r_lo;
    logic [2:0]    r_count;
    logic          r_busy;
    logic          r_done;
    logic [DW-1:0] r_q;
    logic [DW-1:0] r_r;
    logic          r_dz;
    logic          r_ov;

    logic [DW:0]   w_p_next;
    logic          w_qbit;
    logic [DW-1:0] w_lo_next;

    div_step #(.DW(DW)) u_step (
        .i_p      (r_p[DW-1:0]),
        .i_inbit  (r_lo[DW-1]),
        .i_xr     (r_xr),
        .o_p_next (w_p_next),
        .o_qbit   (w_qbit)
    );

    assign w_lo_next = {r_lo[DW-2:0], w_qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_xr    <= '0;
            r_p     <= '0;
            r_lo    <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_dz    <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_xr    <= X;
                        r_p     <= {1'b0, Z[2*DW-1:DW]};
                        r_lo    <= Z[DW-1:0];
                        r_dz    <= 1'b0;
                        r_ov    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // An error result is registered on the first CHECK cycle; the raised flag
                    // holds CHECK one more cycle so the error done lands two edges after start.
                    if (r_dz || r_ov) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_xr == '0) begin
                        r_dz <= 1'b1;
                        r_q  <= SAT;
                        r_r  <= SAT;
                    end else if (r_p[DW-1:0] >= r_xr) begin
                        r_ov <= 1'b1;
                        r_q  <= SAT;
                        r_r  <= SAT;
                    end else begin
                        r_count <= '0;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_p     <= w_p_next;
                    r_lo    <= w_lo_next;
                    r_count <= r_count + 3'd1;
                    if (r_count == ITER_LAST) begin
                        r_q     <= w_lo_next;
                        r_r     <= w_p_next[DW-1:0];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign Q        = r_q;
    assign R        = r_r;
    assign div_zero = r_dz;
    assign overflow = r_ov;
endmodule

// File: doc/kara_divider.md
Name: kara_divider

Overview:
- Sequential restoring divider; the inverse of the 8x8 Karatsuba multiplier.
- Takes a 16-bit product-width dividend Z and an 8-bit divisor X. Returns an 8-bit quotient Q and an 8-bit remainder R with Z = Q*X + R.
- Used by the datapath to recover a factor from a product, and to self-check multiplier results.
- Start/done handshake, one restoring step per clock.

Parameters:
- DW, 8, divisor/quotient/remainder width (dividend is 2*DW). Only 8 is verified.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- Z  in  16  dividend; captured on the accepting edge
- X  in  8  divisor; captured on the accepting edge
- busy  out  1  high while the operation is in CHECK or ITER
- done  out  1  one-cycle pulse; results valid
- Q  out  8  quotient, held until the next accepted start
- R  out  8  remainder, held until the next accepted start
- div_zero  out  1  divisor was 0; held with Q/R
- overflow  out  1  quotient does not fit in 8 bits; held with Q/R

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, div_zero, overflow = 0.
  - Q = R = 8'h00.
  - Internal P/Lo/count cleared.
  - Takes effect immediately, including mid-operation. The aborted operation produces no done.
- States: IDLE, CHECK, ITER, DONE; encoding 2'b00..2'b11.
- IDLE:
  - start=1 at edge E0: latch Xr=X, P={1'b0,Z[15:8]}, Lo=Z[7:0]; clear div_zero and overflow; go to CHECK.
  - Q and R keep their old values until DONE.
- CHECK (edge E1):
  - Xr==0: div_zero=1, Q=R=8'hFF, go to DONE.
  - Else P[7:0]>=Xr: overflow=1, Q=R=8'hFF, go to DONE.
  - Else: count=0, go to ITER.
  - div_zero takes priority over overflow.
- ITER (edges E2..E9, one step per edge):
  - T = {P[7:0], Lo[7]} (9 bits).
  - If T>=Xr: P=T-Xr, qbit=1; else P=T, qbit=0.
  - Lo = {Lo[6:0], qbit}; count++.
  - On the 8th step (E9): Q=Lo_next, R=P_next[7:0], go to DONE.
  - Invariant P<Xr, so R always fits in 8 bits.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - Next edge returns to IDLE.
  - start is ignored in DONE.
- Latency, with start accepted at E0:
  - Normal: done high between E9 and E10.
  - Error: done high between E2 and E3.
  - Minimum start-to-start spacing: 11 cycles normal, 4 cycles error.
- start while busy or in DONE: ignored. No queuing; inputs are not re-sampled.
- Z and X may change after E0 without affecting the result.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package kara_pkg holds:
  - DW=8 and ZW=16.
  - State localparams S_IDLE, S_CHECK, S_ITER, S_DONE.
  - ITER_LAST=7.
  - Saturation value SAT=8'hFF.
- One combinational sub-module, div_step: inputs P[7:0], inbit, Xr; outputs P_next[8:0], qbit. It performs the single restoring compare/subtract.
- The FSM, registers and counter live in kara_divider.

Test Plan:
- Z=16'd221, X=13 -> Q=17, R=0, no flags; done exactly 9 edges after the start edge, busy high for E0..E9.
- Z=16'h1234, X=8'h56 -> Q=8'h36, R=8'h10; then Z=16'hFEFF, X=8'hFF -> Q=8'hFF, R=8'hFE, overflow=0 (upper boundary).
- X=0, any Z -> div_zero=1, overflow=0, Q=R=8'hFF, done 2 edges after start. Also Z=16'hFFFF, X=8'hFF -> overflow=1, Q=R=8'hFF.
- Pulse start again at E4 with a different Z/X, and change the inputs after E0 -> the first result is unaffected, only one done occurs, and the second start is not accepted.
- Assert rst_n=0 during ITER (after E5) -> all outputs 0 immediately, no done; then a fresh start with Z=16'd1000, X=7 -> Q=142, R=6.
- Random sweep of 10k Z/X pairs against a reference model Q=Z/X, R=Z%X when X!=0 and Z[15:8]<X. Flags must match the CHECK rules in every other case.
